// File: rtl/split_4o_pkg.sv
// Shared definitions for the channel-split layer block: branch encoding and
// elaboration-time sizing helpers.
package split_4o_pkg;

    typedef enum logic [1:0] {
        B1 = 2'd0,
        B2 = 2'd1,
        B3 = 2'd2,
        B4 = 2'd3
    } branch_e;

    localparam int NUM_BRANCH = 4;

    // Bits needed to index value distinct states; clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic branch_e next_branch(input branch_e b);
        case (b)
            B1:      return B2;
            B2:      return B3;
            B3:      return B4;
            B4:      return B1;
            default: return B1;
        endcase
    endfunction

endpackage

// File: rtl/split_4o_wrap_counter.sv
// Enable-gated counter that wraps to zero after reaching max-1; the wrap
// point is a run-time input so one instance can serve several branch sizes.
module wrap_counter
    import split_4o_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = clog2(MAX) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] max,
    output logic [W-1:0] count,
    output logic         last
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign last  = (count_q == (max - W'(1)));
    assign count = count_q;

    // Next count: wrap on the final value, otherwise step when enabled.
    always_comb begin
        count_d = count_q;
        if (en) begin
            if (last) begin
                count_d = '0;
            end else begin
                count_d = count_q + W'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/split_4o.sv
// Channel split: routes a per-pixel concatenated stream (CH_1..CH_4 words per
// position) into four branch streams with one cycle of latency.
module split_4o
    import split_4o_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CH_1       = 1,
    parameter int CH_2       = 1,
    parameter int CH_3       = 1,
    parameter int CH_4       = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out_1,
    output logic [DATA_WIDTH-1:0] pxl_out_2,
    output logic [DATA_WIDTH-1:0] pxl_out_3,
    output logic [DATA_WIDTH-1:0] pxl_out_4,
    output logic                  valid_out_1,
    output logic                  valid_out_2,
    output logic                  valid_out_3,
    output logic                  valid_out_4,
    output logic                  frame_done
);

    localparam int CH_12   = (CH_1 > CH_2) ? CH_1 : CH_2;
    localparam int CH_34   = (CH_3 > CH_4) ? CH_3 : CH_4;
    localparam int CH_MAX  = (CH_12 > CH_34) ? CH_12 : CH_34;
    localparam int CH_W    = clog2(CH_MAX) + 1;
    localparam int PIX_MAX = WIDTH * WIDTH;
    localparam int PIX_W   = clog2(PIX_MAX) + 1;

    generate
        if (CH_1 < 1 || CH_2 < 1 || CH_3 < 1 || CH_4 < 1 || WIDTH < 1) begin : g_param_check
            $error("split_4o: every CH_k and WIDTH must be at least 1");
        end
    endgenerate

    branch_e                 sel_q;
    branch_e                 sel_d;
    logic [DATA_WIDTH-1:0]   pxl_q [NUM_BRANCH];
    logic [DATA_WIDTH-1:0]   pxl_d [NUM_BRANCH];
    logic [NUM_BRANCH-1:0]   valid_q;
    logic [NUM_BRANCH-1:0]   valid_d;
    logic                    frame_done_q;
    logic                    frame_done_d;

    logic [CH_W-1:0]         ch_max;
    logic                    ch_last;
    logic                    pix_en;
    logic                    pix_last;
    logic [CH_W-1:0]         unused_ch_cnt;
    logic [PIX_W-1:0]        unused_pix_cnt;

    // Words-per-position of the branch currently being filled.
    always_comb begin
        case (sel_q)
            B1:      ch_max = CH_W'(CH_1);
            B2:      ch_max = CH_W'(CH_2);
            B3:      ch_max = CH_W'(CH_3);
            B4:      ch_max = CH_W'(CH_4);
            default: ch_max = CH_W'(CH_1);
        endcase
    end

    assign pix_en = valid_in & ch_last & (sel_q == B4);

    wrap_counter #(
        .MAX (CH_MAX),
        .W   (CH_W)
    ) u_ch_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (valid_in),
        .max   (ch_max),
        .count (unused_ch_cnt),
        .last  (ch_last)
    );

    wrap_counter #(
        .MAX (PIX_MAX),
        .W   (PIX_W)
    ) u_pix_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (pix_en),
        .max   (PIX_W'(PIX_MAX)),
        .count (unused_pix_cnt),
        .last  (pix_last)
    );

    // Routing and branch sequencing; idle cycles freeze sel and drop all valids.
    always_comb begin
        sel_d        = sel_q;
        pxl_d        = pxl_q;
        valid_d      = '0;
        frame_done_d = 1'b0;
        if (valid_in) begin
            pxl_d[sel_q]   = pxl_in;
            valid_d[sel_q] = 1'b1;
            if (ch_last) begin
                sel_d = next_branch(sel_q);
            end else begin
                sel_d = sel_q;
            end
            frame_done_d = pix_en & pix_last;
        end else begin
            sel_d = sel_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q        <= B1;
            valid_q      <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < NUM_BRANCH; i++) begin
                pxl_q[i] <= '0;
            end
        end else begin
            sel_q        <= sel_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            for (int i = 0; i < NUM_BRANCH; i++) begin
                pxl_q[i] <= pxl_d[i];
            end
        end
    end

    assign pxl_out_1   = pxl_q[0];
    assign pxl_out_2   = pxl_q[1];
    assign pxl_out_3   = pxl_q[2];
    assign pxl_out_4   = pxl_q[3];
    assign valid_out_1 = valid_q[0];
    assign valid_out_2 = valid_q[1];
    assign valid_out_3 = valid_q[2];
    assign valid_out_4 = valid_q[3];
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_split_4o.sv
// Directed bench for split_4o: one instance with WIDTH=2, CH=1,1,1,1 and one
// with WIDTH=1, CH=2,1,3,1.
module tb_split_4o;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, va_in, vb_in;
    logic [31:0] pa_in, pb_in;
    logic [31:0] a_p1, a_p2, a_p3, a_p4, b_p1, b_p2, b_p3, b_p4;
    logic        a_v1, a_v2, a_v3, a_v4, b_v1, b_v2, b_v3, b_v4;
    logic        a_fd, b_fd;

    int          total, bad;
    int          a_word, b_word, a_fd_cnt, b_fd_cnt;
    logic [31:0] exp_pa [4];
    logic [31:0] exp_pb [4];
    int          b_br [7] = '{0, 0, 1, 2, 2, 2, 3};

    split_4o #(.WIDTH(2), .CH_1(1), .CH_2(1), .CH_3(1), .CH_4(1), .DATA_WIDTH(32)) u_dut_a (
        .clk(clk), .reset(rst_a), .valid_in(va_in), .pxl_in(pa_in),
        .pxl_out_1(a_p1), .pxl_out_2(a_p2), .pxl_out_3(a_p3), .pxl_out_4(a_p4),
        .valid_out_1(a_v1), .valid_out_2(a_v2), .valid_out_3(a_v3), .valid_out_4(a_v4),
        .frame_done(a_fd)
    );

    split_4o #(.WIDTH(1), .CH_1(2), .CH_2(1), .CH_3(3), .CH_4(1), .DATA_WIDTH(32)) u_dut_b (
        .clk(clk), .reset(rst_b), .valid_in(vb_in), .pxl_in(pb_in),
        .pxl_out_1(b_p1), .pxl_out_2(b_p2), .pxl_out_3(b_p3), .pxl_out_4(b_p4),
        .valid_out_1(b_v1), .valid_out_2(b_v2), .valid_out_3(b_v3), .valid_out_4(b_v4),
        .frame_done(b_fd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle on instance A; branch = word mod 4, frame end every 16 words.
    task automatic cyc_a(input logic v, input logic [31:0] d);
        logic [3:0] ev;
        logic       efd;
        va_in = v;
        pa_in = d;
        @(posedge clk);
        #1;
        ev  = 4'b0000;
        efd = 1'b0;
        if (v) begin
            ev[a_word % 4]     = 1'b1;
            exp_pa[a_word % 4] = d;
            efd                = ((a_word % 16) == 15);
            a_word++;
        end
        va_in = 1'b0;
        check("a_valid", {28'd0, a_v4, a_v3, a_v2, a_v1}, {28'd0, ev});
        check("a_pxl1", a_p1, exp_pa[0]);
        check("a_pxl2", a_p2, exp_pa[1]);
        check("a_pxl3", a_p3, exp_pa[2]);
        check("a_pxl4", a_p4, exp_pa[3]);
        check("a_frame_done", {31'd0, a_fd}, {31'd0, efd});
        if (a_fd) a_fd_cnt++;
    endtask

    // One cycle on instance B; branch order per frame is 1,1,2,3,3,3,4.
    task automatic cyc_b(input logic v, input logic [31:0] d);
        logic [3:0] ev;
        logic       efd;
        vb_in = v;
        pb_in = d;
        @(posedge clk);
        #1;
        ev  = 4'b0000;
        efd = 1'b0;
        if (v) begin
            ev[b_br[b_word % 7]]     = 1'b1;
            exp_pb[b_br[b_word % 7]] = d;
            efd                      = ((b_word % 7) == 6);
            b_word++;
        end
        vb_in = 1'b0;
        check("b_valid", {28'd0, b_v4, b_v3, b_v2, b_v1}, {28'd0, ev});
        check("b_pxl1", b_p1, exp_pb[0]);
        check("b_pxl2", b_p2, exp_pb[1]);
        check("b_pxl3", b_p3, exp_pb[2]);
        check("b_pxl4", b_p4, exp_pb[3]);
        check("b_frame_done", {31'd0, b_fd}, {31'd0, efd});
        if (b_fd) b_fd_cnt++;
    endtask

    initial begin
        total = 0; bad = 0;
        a_word = 0; b_word = 0; a_fd_cnt = 0; b_fd_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            exp_pa[i] = 32'd0;
            exp_pb[i] = 32'd0;
        end
        rst_a = 1'b1; rst_b = 1'b1;
        va_in = 1'b0; vb_in = 1'b0; pa_in = 32'd0; pb_in = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_valid", {28'd0, a_v4, a_v3, a_v2, a_v1}, 32'd0);
        check("rst_a_pxl", a_p1 | a_p2 | a_p3 | a_p4, 32'd0);
        check("rst_a_fd", {31'd0, a_fd}, 32'd0);
        check("rst_b_valid", {28'd0, b_v4, b_v3, b_v2, b_v1}, 32'd0);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // Basic routing, including hold of branch 1 while 2..4 take data
        a_fd_cnt = 0;
        for (int w = 0; w < 16; w++) begin
            cyc_a(1'b1, 32'(w));
            if (w >= 5 && w <= 7) check("hold_pxl1", a_p1, 32'h0000_0004);
        end
        check("basic_fd_count", 32'(a_fd_cnt), 32'd1);

        // Gaps every other cycle plus a 5-cycle gap before a branch-3 word
        a_fd_cnt = 0;
        for (int w = 0; w < 16; w++) begin
            if (w == 6) repeat (5) cyc_a(1'b0, 32'hDEAD_BEEF);
            cyc_a(1'b1, 32'(w));
            cyc_a(1'b0, 32'hDEAD_BEEF);
        end
        check("gap_fd_count", 32'(a_fd_cnt), 32'd1);

        // Back-to-back frames
        a_fd_cnt = 0;
        for (int w = 0; w < 32; w++) begin
            cyc_a(1'b1, 32'h100 + 32'(w));
            if (w == 16) begin
                check("b2b_w16_valid1", {31'd0, a_v1}, 32'd1);
                check("b2b_w16_pxl1", a_p1, 32'h110);
            end
        end
        check("b2b_fd_count", 32'(a_fd_cnt), 32'd2);

        // Async reset mid-frame
        for (int w = 0; w < 7; w++) cyc_a(1'b1, 32'h200 + 32'(w));
        #2;
        rst_a = 1'b1;
        #1;
        check("mid_rst_valid", {28'd0, a_v4, a_v3, a_v2, a_v1}, 32'd0);
        check("mid_rst_pxl1", a_p1, 32'd0);
        check("mid_rst_pxl4", a_p4, 32'd0);
        check("mid_rst_fd", {31'd0, a_fd}, 32'd0);
        a_word = 0;
        for (int i = 0; i < 4; i++) exp_pa[i] = 32'd0;
        @(negedge clk);
        rst_a = 1'b0;
        a_fd_cnt = 0;
        for (int w = 0; w < 16; w++) cyc_a(1'b1, 32'h300 + 32'(w));
        check("post_rst_fd_count", 32'(a_fd_cnt), 32'd1);

        // Unequal channel counts, continuous then gapped frame
        b_fd_cnt = 0;
        for (int i = 0; i < 7; i++) cyc_b(1'b1, 32'hA0 + 32'(i));
        check("uneq_pxl3_last", b_p3, 32'hA5);
        for (int i = 0; i < 7; i++) begin
            cyc_b(1'b1, 32'hB0 + 32'(i));
            cyc_b(1'b0, 32'h0);
        end
        check("uneq_fd_count", 32'(b_fd_cnt), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/split_4o.md
Name: split_4o

Overview:
- Channel-split block for the Inception-style layer datapath. It is the inverse of the 4-input filter-concat merge.
- Takes one concatenated pixel stream, interleaved per spatial position as CH_1 words, then CH_2, then CH_3, then CH_4.
- Routes each word to one of four branch output streams, each with its own valid.
- Sits at the input of multi-branch layers that consume a pre-concatenated feature map. Also serves as the bench-side model for checking merge output ordering.

Parameters:
- WIDTH, 8, spatial side length. A frame is WIDTH*WIDTH pixel positions.
- CH_1, 1, words per pixel position routed to branch 1 (must be >= 1).
- CH_2, 1, words per pixel position routed to branch 2 (must be >= 1).
- CH_3, 1, words per pixel position routed to branch 3 (must be >= 1).
- CH_4, 1, words per pixel position routed to branch 4 (must be >= 1).
- DATA_WIDTH, 32, word width in bits.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- valid_in  input  1  pxl_in carries a word this cycle.
- pxl_in  input  DATA_WIDTH  concatenated stream word.
- pxl_out_1..pxl_out_4  output  DATA_WIDTH each  branch data, registered.
- valid_out_1..valid_out_4  output  1 each  branch word valid, registered.
- frame_done  output  1  one-cycle pulse after the last word of a frame.

Behaviour:
- Reset (async, active-high):
  - All pxl_out_k = 0, all valid_out_k = 0, frame_done = 0.
  - sel = B1, ch_cnt = 0, pix_cnt = 0.
- Interface: no backpressure, valid-only protocol. Every valid_in word is consumed in the cycle it is presented.
- Latency: 1 cycle. A word accepted at edge n appears on pxl_out_k with valid_out_k = 1 after edge n.
- Routing, on a cycle with valid_in = 1 and current sel = Bk:
  - pxl_out_k <= pxl_in and valid_out_k <= 1.
  - All other valid_out_j <= 0. Their pxl_out_j hold their previous value.
- Idle cycle (valid_in = 0):
  - All valid_out <= 0 and frame_done <= 0.
  - sel, ch_cnt and pix_cnt hold, so gaps may fall anywhere, including mid-branch.
- State machine sel: B1 -> B2 -> B3 -> B4 -> B1. It advances only on a valid word where ch_cnt == CH_k-1; ch_cnt then resets to 0. Otherwise ch_cnt increments.
- Pixel counter:
  - pix_cnt increments on the last word of B4.
  - If pix_cnt == WIDTH*WIDTH-1 at that word, pix_cnt wraps to 0 and frame_done <= 1 for exactly one cycle, coincident with the last valid_out_4.
- Back-to-back frames need no idle cycle. The first word of the next frame is routed to B1 on the cycle after the wrap.
- Counter widths:
  - ch_cnt is clog2(max CH_k)+1 bits.
  - pix_cnt is clog2(WIDTH*WIDTH)+1 bits.
  - No overflow is possible inside legal ranges.
- Reset mid-frame: state is cleared immediately. The next valid word is treated as word 0 of B1 of pixel 0. No partial frame_done is issued.
- CH_k = 1: sel advances on every valid word while in Bk.
- Parameter check: any CH_k < 1 or WIDTH < 1 triggers an elaboration-time error ($error in a generate-if).

Decomposition:
- Shared layer package:
  - Branch-select encoding: B1..B4 as a 2-bit enum.
  - A clog2 helper function.
- One natural sub-module, wrap_counter. Parameters MAX and W; ports clk, reset, en, count, last, where last = (count == MAX-1) and the counter wraps to 0.
  - Instantiated as the channel counter, whose MAX is muxed per branch via the CH_k selected by sel. Implemented as a max input port.
  - Instantiated as the pixel counter, with MAX = WIDTH*WIDTH.
- Routing and output registers stay in split_4o.

Test Plan:
- Basic routing. WIDTH=2, CH=1,1,1,1; feed words 0..15 continuously.
  - Branch k receives words k-1, k+3, k+7, k+11.
  - frame_done pulses once, the cycle word 15 appears on pxl_out_4.
- Unequal channels. WIDTH=1, CH=2,1,3,1; feed A,B,C,D,E,F,G.
  - Branch 1 gets A,B; branch 2 gets C; branch 3 gets D,E,F; branch 4 gets G.
  - frame_done coincides with G.
- Gaps. Same configuration as Basic routing, with valid_in low every other cycle and a 5-cycle gap inside branch 3.
  - Output sequence is identical to Basic routing.
  - No valid_out asserted during gaps; frame_done asserted exactly once.
- Back-to-back frames. Two frames of 16 words with no gap.
  - frame_done pulses at word 15 and word 31.
  - Word 16 is routed to branch 1.
- Async reset mid-frame. Assert reset between clock edges after word 6.
  - Outputs go to 0 immediately.
  - After release, the next word goes to branch 1, and frame_done fires only after 16 further words.
- Hold check. Non-selected pxl_out_j keep their last value while valid_out_j = 0.
  - e.g. pxl_out_1 stays 0x00000004 while branches 2-4 receive data.
